// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard -> NES joypad input stage:
//   - receive FSM state encoding
//   - Set-2 scan-code constants (prefixes and mapped keys)
//   - NES controller bit indices inside PAD_DATA
//   - helper functions: odd-parity check and keymap lookup
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Receive FSM states; one frame = start, 8 data, parity, stop
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Scan-code prefixes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    // Mapped key codes (arrows only count when preceded by SC_EXT)
    localparam logic [7:0] SC_A      = 8'h1A;
    localparam logic [7:0] SC_B      = 8'h22;
    localparam logic [7:0] SC_SELECT = 8'h59;
    localparam logic [7:0] SC_START  = 8'h5A;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // NES controller bit positions in PAD_DATA
    localparam logic [2:0] PAD_A      = 3'd0;
    localparam logic [2:0] PAD_B      = 3'd1;
    localparam logic [2:0] PAD_SELECT = 3'd2;
    localparam logic [2:0] PAD_START  = 3'd3;
    localparam logic [2:0] PAD_UP     = 3'd4;
    localparam logic [2:0] PAD_DOWN   = 3'd5;
    localparam logic [2:0] PAD_LEFT   = 3'd6;
    localparam logic [2:0] PAD_RIGHT  = 3'd7;

    // Result of a keymap lookup
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Map {extended flag, code} to a joypad bit; keypad codes without E0 miss
    function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = PAD_A;
        case ({ext, code})
            {1'b0, SC_A}:      m.idx = PAD_A;
            {1'b0, SC_B}:      m.idx = PAD_B;
            {1'b0, SC_SELECT}: m.idx = PAD_SELECT;
            {1'b0, SC_START}:  m.idx = PAD_START;
            {1'b1, SC_UP}:     m.idx = PAD_UP;
            {1'b1, SC_DOWN}:   m.idx = PAD_DOWN;
            {1'b1, SC_LEFT}:   m.idx = PAD_LEFT;
            {1'b1, SC_RIGHT}:  m.idx = PAD_RIGHT;
            default: begin
                m.hit = 1'b0;
                m.idx = PAD_A;
            end
        endcase
        return m;
    endfunction

endpackage : ps2_pkg

// File: rtl/ps2_pad_decoder_if.sv
// -----------------------------------------------------------------------------
// ps2_pad_decoder_if
// Bundles the PS/2 pin inputs and the decoded joypad outputs.
//   PS2_CLK, PS2_DAT : raw PS/2 lines (device -> decoder, asynchronous)
//   PAD_DATA[7:0]    : joypad state, 1 = pressed
//   CODE_VALID       : one-cycle strobe, good byte received
//   CODE[7:0]        : last good byte
//   FRAME_ERR        : one-cycle strobe, parity/stop/timeout error
// slave  : the decoder side
// master : the keyboard/consumer side (drives the lines, reads results)
// -----------------------------------------------------------------------------
interface ps2_pad_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] PAD_DATA;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       FRAME_ERR;

    modport slave (
        input  PS2_CLK,
        input  PS2_DAT,
        output PAD_DATA,
        output CODE_VALID,
        output CODE,
        output FRAME_ERR
    );

    modport master (
        output PS2_CLK,
        output PS2_DAT,
        input  PAD_DATA,
        input  CODE_VALID,
        input  CODE,
        input  FRAME_ERR
    );
endinterface : ps2_pad_decoder_if

// File: rtl/ps2_rx_frame.sv
// -----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host frame receiver: synchronizes the raw lines, detects
// falling edges of the PS/2 clock, assembles 11-bit frames and checks them.
// Strobes are combinational in the stop-bit fall cycle (or timeout cycle);
// the parent registers them.
//   clk_i, rst_ni    : system clock, async active-low reset
//   ps2_clk_i/dat_i  : raw asynchronous PS/2 lines
//   byte_o           : assembled data byte
//   byte_valid_o     : good frame completes this cycle
//   frame_err_o      : parity/stop error or timeout this cycle
//   timeout_o        : partial frame abandoned this cycle
// -----------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int          TMO_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       timeout_o
);

    // The counter is zero in the cycle after a fall, so when its next value
    // would reach TIMEOUT_CYC-1 the TIMEOUT_CYC-th cycle since the fall is
    // current; the registered error then lands exactly TIMEOUT_CYC cycles
    // after the fall cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 32'd2);

    rx_state_e        state_q, state_d;
    logic             clk_s1_q, clk_s2_q;
    logic             dat_s1_q, dat_s2_q;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fall_s;
    logic             tmo_hit_s;

    assign fall_s    = clk_s2_q & ~clk_s1_q;
    assign tmo_hit_s = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);

    // Two-flop synchronizers; reset to the idle-high line level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: timeout wins over a same-cycle fall
    always_comb begin
        state_d = state_q;
        if (tmo_hit_s) begin
            state_d = ST_IDLE;
        end else if (fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: frame verdict in the stop-bit fall cycle or on timeout
    always_comb begin
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        timeout_o    = tmo_hit_s;
        if (tmo_hit_s) begin
            frame_err_o = 1'b1;
        end else if (fall_s && (state_q == ST_STOP)) begin
            if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                byte_valid_o = 1'b1;
            end else begin
                frame_err_o = 1'b1;
            end
        end else begin
            byte_valid_o = 1'b0;
        end
    end

    assign byte_o = shift_q;

    // Datapath next values: shift register, bit counter, parity, timeout counter
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (fall_s && !tmo_hit_s) begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                end
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    par_d = dat_s2_q;
                end
                default: begin
                    par_d = par_q;
                end
            endcase
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (fall_s || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule : ps2_rx_frame

// File: rtl/ps2_pad_decoder.sv
// -----------------------------------------------------------------------------
// ps2_pad_decoder
// PS/2 keyboard front end for the NES core: receives Set-2 scan codes,
// tracks the F0 (break) and E0 (extended) prefixes and keeps an 8-bit
// controller-1 button state.
//   iCLK   : 50 MHz system clock
//   iRST_N : asynchronous active-low reset
//   bus    : PS2_CLK/PS2_DAT in; PAD_DATA, CODE_VALID, CODE, FRAME_ERR out
//            (all outputs registered)
// -----------------------------------------------------------------------------
module ps2_pad_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int          TMO_W       = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    ps2_pad_decoder_if.slave      bus
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_err_s;
    logic       rx_tmo_s;
    key_map_t   map_s;

    logic [7:0] pad_q, pad_d;
    logic [7:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMO_W       (TMO_W)
    ) u_rx (
        .clk_i        (iCLK),
        .rst_ni       (iRST_N),
        .ps2_clk_i    (bus.PS2_CLK),
        .ps2_dat_i    (bus.PS2_DAT),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_err_s),
        .timeout_o    (rx_tmo_s)
    );

    assign map_s = key_lookup(ext_q, rx_byte_s);

    // Scan-code decode: prefixes arm flags, any other good byte consumes them
    always_comb begin
        pad_d        = pad_q;
        code_d       = code_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        code_valid_d = 1'b0;
        // rx never raises valid and error together
        frame_err_d  = rx_err_s;
        if (rx_tmo_s) begin
            // an abandoned frame also abandons any pending prefix sequence
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_valid_s) begin
            code_d       = rx_byte_s;
            code_valid_d = 1'b1;
            if (rx_byte_s == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte_s == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                if (map_s.hit) begin
                    pad_d[map_s.idx] = ~brk_q;
                end else begin
                    pad_d = pad_q;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end else begin
            code_d = code_q;
        end
    end

    // Output and prefix-flag registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pad_q        <= 8'h00;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
        end else begin
            pad_q        <= pad_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
        end
    end

    assign bus.PAD_DATA   = pad_q;
    assign bus.CODE       = code_q;
    assign bus.CODE_VALID = code_valid_q;
    assign bus.FRAME_ERR  = frame_err_q;

endmodule : ps2_pad_decoder
